// File: rtl/cpu_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | cpu_pkg                                                              |
// | Shared types and constants for the 5-stage pipeline hazard control.  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package cpu_pkg;

  // Hazard sequencer state; the value 3 is illegal and recovers to RUN.
  typedef enum logic [1:0] {
    HZ_RUN     = 2'd0,
    HZ_LDSTALL = 2'd1,
    HZ_MEMWAIT = 2'd2,
    HZ_ILLEGAL = 2'd3
  } hz_state_t;

  // Architectural zero register; never a real producer.
  localparam logic [4:0] REG_ZR = 5'd31;

  // Stage-register enable and NOP-insertion bundle.
  typedef struct packed {
    logic pc_we;
    logic if2rf_we;
    logic rf2ex_we;
    logic ex2mem_we;
    logic mem2wb_we;
    logic if2rf_flush;
    logic rf2ex_bubble;
    logic mem2wb_bubble;
  } hz_ctrl_t;

  // Everything advances, nothing is squashed.
  localparam hz_ctrl_t HZ_CTRL_RUN     = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
  // Hold PC and IF/RF, push a bubble into EX.
  localparam hz_ctrl_t HZ_CTRL_LOADUSE = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
  // Freeze the pipe; WB retires once then receives NOPs.
  localparam hz_ctrl_t HZ_CTRL_MEMWAIT = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
  // NOP bundle: no register advances and every flush/bubble line is active.
  localparam hz_ctrl_t HZ_CTRL_NOP     = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};

  // True when a used source register matches a real (non-X31) destination.
  function automatic logic reg_match(input logic [4:0] src, input logic used,
                                     input logic [4:0] dst);
    return used && (src == dst) && (dst != REG_ZR);
  endfunction

endpackage
`default_nettype wire

// File: rtl/sat_counter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | sat_counter                                                          |
// | Up counter that sticks at all-ones; synchronous clear.               |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  input  logic         clear,
  output logic [W-1:0] count
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  // Next count: clear wins, otherwise increment until all-ones.
  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (inc && (count_q != {W{1'b1}})) begin
      count_d = count_q + W'(1);
    end
  end

  // Count register with asynchronous reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule
`default_nettype wire

// File: rtl/pipe_hazard_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | pipe_hazard_ctrl                                                     |
// | Stall/flush sequencer for the IF/RF/EX/MEM/WB pipeline: load-use     |
// | stalls, taken-branch fetch squash and data-memory waits.             |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module pipe_hazard_ctrl
  import cpu_pkg::*;
#(
  parameter int CNT_W       = 32,
  parameter int MEM_TIMEOUT = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       rf_rn,
  input  logic             rf_rn_used,
  input  logic [4:0]       rf_rb,
  input  logic             rf_rb_used,
  input  logic             rf_br_taken,
  input  logic [4:0]       ex_rd,
  input  logic             ex_regwrite,
  input  logic             ex_load,
  input  logic             mem_req,
  input  logic             mem_ready,
  output logic             pc_we,
  output logic             if2rf_we,
  output logic             rf2ex_we,
  output logic             ex2mem_we,
  output logic             mem2wb_we,
  output logic             if2rf_flush,
  output logic             rf2ex_bubble,
  output logic             mem2wb_bubble,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt,
  output logic             mem_timeout
);

  localparam int              WAIT_W    = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

  hz_state_t         state_q, state_d;
  logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic              mem_timeout_q, mem_timeout_d;
  hz_ctrl_t          ctrl;
  hz_ctrl_t          ctrl_out;
  logic              mem_wait;
  logic              load_use;

  // Mealy decode: memory wait beats load-use, which beats the branch squash.
  always_comb begin
    mem_wait = mem_req && !mem_ready;
    load_use = ex_load && ex_regwrite &&
               (reg_match(rf_rn, rf_rn_used, ex_rd) || reg_match(rf_rb, rf_rb_used, ex_rd));
    ctrl     = HZ_CTRL_RUN;
    state_d  = HZ_RUN;
    if (mem_wait) begin
      ctrl    = HZ_CTRL_MEMWAIT;
      state_d = HZ_MEMWAIT;
    end else begin
      case (state_q)
        // MEMWAIT with ready falls through to the normal RUN decode.
        HZ_RUN, HZ_MEMWAIT: begin
          if (load_use) begin
            ctrl    = HZ_CTRL_LOADUSE;
            state_d = HZ_LDSTALL;
          end else begin
            ctrl.if2rf_flush = rf_br_taken;
          end
        end
        // EX holds a bubble, so no re-detection; a taken branch is honoured now.
        HZ_LDSTALL: ctrl.if2rf_flush = rf_br_taken;
        default: ctrl = HZ_CTRL_RUN;
      endcase
    end
    ctrl_out = reset ? HZ_CTRL_NOP : ctrl;
  end

  // Consecutive-MEMWAIT counter and sticky timeout flag.
  always_comb begin
    wait_cnt_d    = '0;
    mem_timeout_d = mem_timeout_q;
    if (state_q == HZ_MEMWAIT) begin
      if (wait_cnt_q == WAIT_LAST) begin
        mem_timeout_d = 1'b1;
        wait_cnt_d    = wait_cnt_q;
      end else begin
        wait_cnt_d = wait_cnt_q + WAIT_W'(1);
      end
    end
  end

  // State, wait counter and error flag registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= HZ_RUN;
      wait_cnt_q    <= '0;
      mem_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      wait_cnt_q    <= wait_cnt_d;
      mem_timeout_q <= mem_timeout_d;
    end
  end

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (!ctrl_out.pc_we && !reset),
    .clear (1'b0),
    .count (stall_cnt)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (ctrl_out.if2rf_flush && !reset),
    .clear (1'b0),
    .count (flush_cnt)
  );

  assign pc_we         = ctrl_out.pc_we;
  assign if2rf_we      = ctrl_out.if2rf_we;
  assign rf2ex_we      = ctrl_out.rf2ex_we;
  assign ex2mem_we     = ctrl_out.ex2mem_we;
  assign mem2wb_we     = ctrl_out.mem2wb_we;
  assign if2rf_flush   = ctrl_out.if2rf_flush;
  assign rf2ex_bubble  = ctrl_out.rf2ex_bubble;
  assign mem2wb_bubble = ctrl_out.mem2wb_bubble;
  assign state         = state_q;
  assign mem_timeout   = mem_timeout_q;

endmodule
`default_nettype wire

// File: tb/tb_pipe_hazard_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_pipe_hazard_ctrl                                                  |
// | Directed vectors with a scoreboard queue and a decoupled monitor.    |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_pipe_hazard_ctrl;

  localparam int CNT_W       = 4;
  localparam int MEM_TIMEOUT = 8;

  // {pc_we, if2rf_we, rf2ex_we, ex2mem_we, mem2wb_we, if2rf_flush, rf2ex_bubble, mem2wb_bubble}
  localparam logic [7:0] C_RUN = 8'b11111_000;
  localparam logic [7:0] C_FLS = 8'b11111_100;
  localparam logic [7:0] C_LDU = 8'b00111_010;
  localparam logic [7:0] C_MWT = 8'b00001_001;
  localparam logic [7:0] C_RST = 8'b00000_111;
  localparam logic [1:0] S_RUN = 2'd0;
  localparam logic [1:0] S_LD  = 2'd1;
  localparam logic [1:0] S_MW  = 2'd2;

  logic clk = 1'b0;
  logic reset;
  logic [4:0] rf_rn, rf_rb, ex_rd;
  logic rf_rn_used, rf_rb_used, rf_br_taken, ex_regwrite, ex_load, mem_req, mem_ready;
  logic pc_we, if2rf_we, rf2ex_we, ex2mem_we, mem2wb_we;
  logic if2rf_flush, rf2ex_bubble, mem2wb_bubble;
  logic [1:0] state;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;
  logic mem_timeout;
  logic [7:0] act_ctrl;

  typedef struct packed {
    logic [7:0]       ctrl;
    logic [1:0]       st;
    logic [CNT_W-1:0] stall;
    logic [CNT_W-1:0] flush;
    logic             tmo;
  } exp_t;

  exp_t exp_q[$];
  int total = 0;
  int bad   = 0;
  logic [CNT_W-1:0] m_stall = '0;
  logic [CNT_W-1:0] m_flush = '0;
  logic m_tmo = 1'b0;

  pipe_hazard_ctrl #(.CNT_W(CNT_W), .MEM_TIMEOUT(MEM_TIMEOUT)) dut (
    .clk(clk), .reset(reset),
    .rf_rn(rf_rn), .rf_rn_used(rf_rn_used), .rf_rb(rf_rb), .rf_rb_used(rf_rb_used),
    .rf_br_taken(rf_br_taken), .ex_rd(ex_rd), .ex_regwrite(ex_regwrite), .ex_load(ex_load),
    .mem_req(mem_req), .mem_ready(mem_ready),
    .pc_we(pc_we), .if2rf_we(if2rf_we), .rf2ex_we(rf2ex_we), .ex2mem_we(ex2mem_we),
    .mem2wb_we(mem2wb_we), .if2rf_flush(if2rf_flush), .rf2ex_bubble(rf2ex_bubble),
    .mem2wb_bubble(mem2wb_bubble), .state(state), .stall_cnt(stall_cnt),
    .flush_cnt(flush_cnt), .mem_timeout(mem_timeout)
  );

  always #5 clk = ~clk;

  assign act_ctrl = {pc_we, if2rf_we, rf2ex_we, ex2mem_we, mem2wb_we,
                     if2rf_flush, rf2ex_bubble, mem2wb_bubble};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Drive one cycle of inputs and queue the expected response.
  task automatic step(input logic [4:0] rn, input logic rnu, input logic [4:0] rb,
                      input logic rbu, input logic br, input logic [4:0] rd,
                      input logic rw, input logic ld, input logic mreq, input logic mrdy,
                      input logic [7:0] ectrl, input logic [1:0] est);
    exp_t e;
    @(negedge clk);
    rf_rn = rn; rf_rn_used = rnu; rf_rb = rb; rf_rb_used = rbu; rf_br_taken = br;
    ex_rd = rd; ex_regwrite = rw; ex_load = ld; mem_req = mreq; mem_ready = mrdy;
    e.ctrl = ectrl; e.st = est; e.stall = m_stall; e.flush = m_flush; e.tmo = m_tmo;
    exp_q.push_back(e);
    if (!ectrl[7] && (m_stall != '1)) m_stall++;
    if (ectrl[2] && (m_flush != '1)) m_flush++;
  endtask

  task automatic idle(input logic [7:0] ectrl, input logic [1:0] est);
    step(5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, ectrl, est);
  endtask

  // Monitor: compare the DUT against the oldest queued expectation each cycle.
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("ctrl", {24'd0, act_ctrl}, {24'd0, e.ctrl});
        check("state", {30'd0, state}, {30'd0, e.st});
        check("stall_cnt", {28'd0, stall_cnt}, {28'd0, e.stall});
        check("flush_cnt", {28'd0, flush_cnt}, {28'd0, e.flush});
        check("mem_timeout", {31'd0, mem_timeout}, {31'd0, e.tmo});
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin : stimulus
    reset = 1'b1;
    rf_rn = '0; rf_rn_used = 1'b0; rf_rb = '0; rf_rb_used = 1'b0; rf_br_taken = 1'b0;
    ex_rd = '0; ex_regwrite = 1'b0; ex_load = 1'b0; mem_req = 1'b0; mem_ready = 1'b0;
    #2;
    check("reset_ctrl", {24'd0, act_ctrl}, {24'd0, C_RST});
    check("reset_state", {30'd0, state}, 32'd0);
    check("reset_cnts", {24'd0, stall_cnt, flush_cnt}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;

    idle(C_RUN, S_RUN);
    // Load-use through Rn, then LDSTALL with all enables.
    step(5'd1, 1'b1, 5'd0, 1'b0, 1'b0, 5'd1, 1'b1, 1'b1, 1'b0, 1'b0, C_LDU, S_RUN);
    step(5'd1, 1'b1, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, C_RUN, S_LD);
    idle(C_RUN, S_RUN);
    // X31 never stalls.
    step(5'd31, 1'b1, 5'd0, 1'b0, 1'b0, 5'd31, 1'b1, 1'b1, 1'b0, 1'b0, C_RUN, S_RUN);
    // Matching Rn that is not used does not stall; used Rb does.
    step(5'd5, 1'b0, 5'd6, 1'b1, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0, C_RUN, S_RUN);
    step(5'd0, 1'b0, 5'd5, 1'b1, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0, C_LDU, S_RUN);
    step(5'd0, 1'b0, 5'd5, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, C_RUN, S_LD);
    // Non-load producer is forwarded, no stall.
    step(5'd3, 1'b1, 5'd0, 1'b0, 1'b0, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0, C_RUN, S_RUN);
    // Taken branch: single-cycle flush.
    step(5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, C_FLS, S_RUN);
    idle(C_RUN, S_RUN);
    // Branch with load-use: stall first, flush in LDSTALL.
    step(5'd2, 1'b1, 5'd0, 1'b0, 1'b1, 5'd2, 1'b1, 1'b1, 1'b0, 1'b0, C_LDU, S_RUN);
    step(5'd2, 1'b1, 5'd0, 1'b0, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, C_FLS, S_LD);
    idle(C_RUN, S_RUN);
    // Three wait cycles, then normal decode (with a branch) on the ready cycle.
    for (int i = 0; i < 3; i++)
      step(5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, C_MWT, (i == 0) ? S_RUN : S_MW);
    step(5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, C_FLS, S_MW);
    idle(C_RUN, S_RUN);
    // Long wait: memory wait beats load-use, flag rises, stall_cnt saturates.
    for (int i = 0; i < 20; i++) begin
      if (i >= MEM_TIMEOUT + 1) m_tmo = 1'b1;
      step(5'd4, 1'b1, 5'd0, 1'b0, 1'b0, 5'd4, 1'b1, 1'b1, 1'b1, 1'b0, C_MWT, (i == 0) ? S_RUN : S_MW);
    end
    step(5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, C_RUN, S_MW);
    idle(C_RUN, S_RUN);
    // Reset mid-wait takes effect without a clock edge.
    step(5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, C_MWT, S_RUN);
    step(5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, C_MWT, S_MW);
    @(negedge clk);
    #3;
    reset = 1'b1;
    #1;
    check("async_rst_ctrl", {24'd0, act_ctrl}, {24'd0, C_RST});
    check("async_rst_state", {30'd0, state}, 32'd0);
    check("async_rst_cnts", {24'd0, stall_cnt, flush_cnt}, 32'd0);
    check("async_rst_tmo", {31'd0, mem_timeout}, 32'd0);
    mem_req = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    m_stall = '0; m_flush = '0; m_tmo = 1'b0;
    idle(C_RUN, S_RUN);
    step(5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, C_FLS, S_RUN);
    idle(C_RUN, S_RUN);

    for (int i = 0; i < 5; i++) begin
      if (exp_q.size() > 0) @(negedge clk);
    end
    #5;
    check("scoreboard_drain", exp_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
